constant_sequencer: RTL

//  Parametrised successor of the datapath constant source. Drives NUM_FIXED

---
 rtl/constant_sequencer_if.sv | 24 ++
 rtl/constant_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/constant_sequencer_if.sv
// Stream port of the constant sequencer: one word per valid/ready beat,
// with a marker on the final beat of each run.
interface constant_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/constant_sequencer.sv
// Fixed constant source plus a programmable up/down/hold/loop sequence
// generator streaming base +/- i*step over a valid/ready port.

module constant_sequencer_checker #(
   parameter int WIDTH = 32
) (
   input logic             clk,
   input logic             reset_n,
   input logic             abort,
   input logic             out_valid,
   input logic             out_ready,
   input logic [WIDTH-1:0] out_data,
   input logic             out_last,
   input logic             busy,
   input logic             done
);
   // a stalled beat must hold its payload unless the run is cancelled
   a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (out_valid && !out_ready && !abort) |=> (out_valid && $stable(out_data) && $stable(out_last)))
      else $error("assertion a_stall_stable violated");

   // out_last only accompanies a valid beat
   a_last_valid: assert property (@(posedge clk) disable iff (!reset_n)
      out_last |-> out_valid)
      else $error("assertion a_last_valid violated");

   // done is only reported from IDLE
   a_done_idle: assert property (@(posedge clk) disable iff (!reset_n)
      done |-> !busy)
      else $error("assertion a_done_idle violated");

   // the stream is valid exactly while the FSM is running
   a_valid_busy: assert property (@(posedge clk) disable iff (!reset_n)
      out_valid == busy)
      else $error("assertion a_valid_busy violated");
endmodule

module constant_sequencer #(
   parameter int WIDTH     = 32,
   parameter int CNT_W     = 8,
   parameter int NUM_FIXED = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   output logic [NUM_FIXED*WIDTH-1:0] fixed_out,
   input  logic                       start,
   input  logic                       abort,
   input  logic [1:0]                 mode,
   input  logic [WIDTH-1:0]           base,
   input  logic [WIDTH-1:0]           step,
   input  logic [CNT_W-1:0]           count,
   constant_sequencer_if.master       stream,
   output logic                       busy,
   output logic                       done
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_LOOP = 2'b01;
   localparam logic [1:0] MODE_HOLD = 2'b10;
   localparam logic [1:0] MODE_DOWN = 2'b11;

   function automatic logic [WIDTH-1:0] next_value(
      input logic [1:0]       m,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] inc
   );
      logic [WIDTH-1:0] nv;
      case (m)
         MODE_UP, MODE_LOOP: nv = cur + inc;
         MODE_HOLD:          nv = cur;
         MODE_DOWN:          nv = cur - inc;
         default:            nv = cur;
      endcase
      return nv;
   endfunction

   for (genvar k = 0; k < NUM_FIXED; k++) begin : g_fixed
      assign fixed_out[k*WIDTH +: WIDTH] = WIDTH'(k);
   end

   logic [0:0]       state_r, state_nxt_s;
   logic [1:0]       mode_r, mode_nxt_s;
   logic [WIDTH-1:0] base_r, base_nxt_s;
   logic [WIDTH-1:0] step_r, step_nxt_s;
   logic [CNT_W-1:0] count_r, count_nxt_s;
   logic [CNT_W-1:0] index_r, index_nxt_s;
   logic [WIDTH-1:0] data_r, data_nxt_s;
   logic             valid_r, valid_nxt_s;
   logic             last_r, last_nxt_s;
   logic             busy_r, busy_nxt_s;
   logic             done_r, done_nxt_s;
   logic             beat_s;

   assign beat_s = valid_r & stream.out_ready;

   // next-state and next-output computation for the sequencer FSM
   always_comb begin
      state_nxt_s = state_r;
      mode_nxt_s  = mode_r;
      base_nxt_s  = base_r;
      step_nxt_s  = step_r;
      count_nxt_s = count_r;
      index_nxt_s = index_r;
      data_nxt_s  = data_r;
      valid_nxt_s = valid_r;
      last_nxt_s  = last_r;
      busy_nxt_s  = busy_r;
      done_nxt_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               mode_nxt_s  = mode;
               base_nxt_s  = base;
               step_nxt_s  = step;
               count_nxt_s = count;
               if (count != {CNT_W{1'b0}}) begin
                  state_nxt_s = RUN;
                  index_nxt_s = {CNT_W{1'b0}};
                  data_nxt_s  = base;
                  valid_nxt_s = 1'b1;
                  last_nxt_s  = (count == CNT_W'(1));
                  busy_nxt_s  = 1'b1;
               end else begin
                  done_nxt_s = 1'b1;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            // abort takes priority; a coincident beat is simply not followed up
            if (abort) begin
               state_nxt_s = IDLE;
               index_nxt_s = {CNT_W{1'b0}};
               valid_nxt_s = 1'b0;
               last_nxt_s  = 1'b0;
               busy_nxt_s  = 1'b0;
            end else if (beat_s) begin
               if (last_r) begin
                  if (mode_r == MODE_LOOP) begin
                     index_nxt_s = {CNT_W{1'b0}};
                     data_nxt_s  = base_r;
                     last_nxt_s  = (count_r == CNT_W'(1));
                  end else begin
                     state_nxt_s = IDLE;
                     index_nxt_s = {CNT_W{1'b0}};
                     valid_nxt_s = 1'b0;
                     last_nxt_s  = 1'b0;
                     busy_nxt_s  = 1'b0;
                     done_nxt_s  = 1'b1;
                  end
               end else begin
                  index_nxt_s = index_r + CNT_W'(1);
                  data_nxt_s  = next_value(mode_r, data_r, step_r);
                  last_nxt_s  = ((index_r + CNT_W'(1)) == (count_r - CNT_W'(1)));
               end
            end else begin
               state_nxt_s = RUN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            index_nxt_s = {CNT_W{1'b0}};
            valid_nxt_s = 1'b0;
            last_nxt_s  = 1'b0;
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         mode_r  <= 2'b00;
         base_r  <= {WIDTH{1'b0}};
         step_r  <= {WIDTH{1'b0}};
         count_r <= {CNT_W{1'b0}};
         index_r <= {CNT_W{1'b0}};
         data_r  <= {WIDTH{1'b0}};
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         mode_r  <= mode_nxt_s;
         base_r  <= base_nxt_s;
         step_r  <= step_nxt_s;
         count_r <= count_nxt_s;
         index_r <= index_nxt_s;
         data_r  <= data_nxt_s;
         valid_r <= valid_nxt_s;
         last_r  <= last_nxt_s;
         busy_r  <= busy_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   assign stream.out_valid = valid_r;
   assign stream.out_data  = data_r;
   assign stream.out_last  = last_r;
   assign busy             = busy_r;
   assign done             = done_r;

   constant_sequencer_checker #(.WIDTH(WIDTH)) u_checker (
      .clk       (clk),
      .reset_n   (reset_n),
      .abort     (abort),
      .out_valid (valid_r),
      .out_ready (stream.out_ready),
      .out_data  (data_r),
      .out_last  (last_r),
      .busy      (busy_r),
      .done      (done_r)
   );
endmodule
